// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared RS(31,27) constants, generator coefficients and encoder state type
package rs_pkg;

    localparam int SYM_W = 5;
    localparam int N     = 31;
    localparam int K     = 27;
    localparam int NPAR  = 4;

    // x^5 = x^2 + 1, low five bits of x^5+x^2+1
    localparam logic [4:0] PRIM_POLY = 5'b00101;

    // g(x) = x^4 + G3*x^3 + G2*x^2 + G1*x + G0
    localparam logic [4:0] G0 = 5'd17;
    localparam logic [4:0] G1 = 5'd9;
    localparam logic [4:0] G2 = 5'd6;
    localparam logic [4:0] G3 = 5'd30;

    typedef enum logic {
        MSG = 1'b0,
        PAR = 1'b1
    } enc_state_t;

endpackage

// File: rtl/gf_mult5.sv
// rtl/gf_mult5.sv - combinational GF(2^5) multiplier over PRIM_POLY
module gf_mult5
    import rs_pkg::*;
(
    input  logic [4:0] i_a,
    input  logic [4:0] i_b,
    output logic [4:0] o_p
);

    logic [4:0] w_acc;
    logic [4:0] w_sh;

    // shift-and-add: w_sh walks i_a * x^i, reduced modulo the field polynomial each step
    always_comb begin
        w_acc = '0;
        w_sh  = i_a;
        for (int i = 0; i < 5; i++) begin
            if (i_b[i]) begin
                w_acc = w_acc ^ w_sh;
            end
            w_sh = {w_sh[3:0], 1'b0} ^ (w_sh[4] ? PRIM_POLY : 5'b00000);
        end
        o_p = w_acc;
    end

endmodule

// File: rtl/rs_encoder.sv
// rtl/rs_encoder.sv - systematic RS(31,27) encoder, optional error injection under RS_ENC_ERR_INJ_EN
module rs_encoder
    import rs_pkg::enc_state_t, rs_pkg::MSG, rs_pkg::PAR, rs_pkg::NPAR,
           rs_pkg::G0, rs_pkg::G1, rs_pkg::G2, rs_pkg::G3;
#(
    parameter int SYM_W = 5,
    parameter int N     = 31,
    parameter int K     = 27
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] datain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] dataout,
    output logic             out_first,
    output logic             out_last
`ifdef RS_ENC_ERR_INJ_EN
    ,
    input  logic             err_en,
    input  logic [4:0]       err_pos,
    input  logic [4:0]       err_val
`endif
);

    if (SYM_W != rs_pkg::SYM_W || N != rs_pkg::N || K != rs_pkg::K) begin : g_bad_param
        $error("rs_encoder supports only SYM_W=5, N=31, K=27");
    end

    enc_state_t r_state;
    enc_state_t w_next_state;

    logic [4:0] r_lfsr0, r_lfsr1, r_lfsr2, r_lfsr3;
    logic [4:0] r_cnt;
    logic [4:0] r_dataout;
    logic       r_out_valid;
    logic       r_out_first;
    logic       r_out_last;

    logic       w_free;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_par_load;
    logic       w_msg_wrap;
    logic       w_par_wrap;
    logic [4:0] w_fb;
    logic [4:0] w_m0, w_m1, w_m2, w_m3;
    logic [4:0] w_inj;

    assign w_fb = datain ^ r_lfsr3;

    gf_mult5 u_mul0 (.i_a(w_fb), .i_b(G0), .o_p(w_m0));
    gf_mult5 u_mul1 (.i_a(w_fb), .i_b(G1), .o_p(w_m1));
    gf_mult5 u_mul2 (.i_a(w_fb), .i_b(G2), .o_p(w_m2));
    gf_mult5 u_mul3 (.i_a(w_fb), .i_b(G3), .o_p(w_m3));

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= MSG;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next state: leave MSG after the 27th accept, leave PAR after the 4th parity load
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MSG: if (w_msg_wrap) w_next_state = PAR;
            PAR: if (w_par_wrap) w_next_state = MSG;
            default: w_next_state = MSG;
        endcase
    end

    // handshake decode; in_ready is held low while reset is asserted
    always_comb begin
        w_free     = !r_out_valid || out_ready;
        w_in_ready = (r_state == MSG) && w_free && !reset;
        w_accept   = in_valid && w_in_ready;
        w_par_load = (r_state == PAR) && w_free;
        w_msg_wrap = w_accept && (r_cnt == 5'(K - 1));
        w_par_wrap = w_par_load && (r_cnt == 5'(NPAR - 1));
    end

`ifdef RS_ENC_ERR_INJ_EN
    logic       r_err_en;
    logic [4:0] r_err_pos;
    logic [4:0] r_err_val;
    logic       w_cur_en;
    logic [4:0] w_cur_pos;
    logic [4:0] w_cur_val;
    logic [4:0] w_sym_idx;

    // symbol 0 uses the live inputs since they are captured on that same accept
    always_comb begin
        w_sym_idx = (r_state == MSG) ? r_cnt : (r_cnt + 5'(K));
        if (r_state == MSG && r_cnt == 5'd0) begin
            w_cur_en  = err_en;
            w_cur_pos = err_pos;
            w_cur_val = err_val;
        end else begin
            w_cur_en  = r_err_en;
            w_cur_pos = r_err_pos;
            w_cur_val = r_err_val;
        end
        w_inj = (w_cur_en && (w_cur_pos == w_sym_idx)) ? w_cur_val : 5'd0;
    end

    // hold the injection settings for the whole codeword
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err_en  <= 1'b0;
            r_err_pos <= '0;
            r_err_val <= '0;
        end else if (w_accept && r_cnt == 5'd0) begin
            r_err_en  <= err_en;
            r_err_pos <= err_pos;
            r_err_val <= err_val;
        end
    end
`else
    assign w_inj = 5'd0;
`endif

    // LFSR, symbol counter and registered output stage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lfsr0     <= '0;
            r_lfsr1     <= '0;
            r_lfsr2     <= '0;
            r_lfsr3     <= '0;
            r_cnt       <= '0;
            r_dataout   <= '0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_lfsr3     <= r_lfsr2 ^ w_m3;
            r_lfsr2     <= r_lfsr1 ^ w_m2;
            r_lfsr1     <= r_lfsr0 ^ w_m1;
            r_lfsr0     <= w_m0;
            r_dataout   <= datain ^ w_inj;
            r_out_valid <= 1'b1;
            r_out_first <= (r_cnt == 5'd0);
            r_out_last  <= 1'b0;
            r_cnt       <= w_msg_wrap ? 5'd0 : (r_cnt + 5'd1);
        end else if (w_par_load) begin
            r_lfsr3     <= r_lfsr2;
            r_lfsr2     <= r_lfsr1;
            r_lfsr1     <= r_lfsr0;
            r_lfsr0     <= '0;
            r_dataout   <= r_lfsr3 ^ w_inj;
            r_out_valid <= 1'b1;
            r_out_first <= 1'b0;
            r_out_last  <= w_par_wrap;
            r_cnt       <= w_par_wrap ? 5'd0 : (r_cnt + 5'd1);
        end else if (w_free) begin
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign dataout   = r_dataout;
    assign out_first = r_out_first;
    assign out_last  = r_out_last;

endmodule

// File: doc/rs_encoder.md
Name: rs_encoder

Overview:
- Systematic RS(31,27) encoder over GF(2^5) with primitive polynomial x^5+x^2+1, correcting t=2 symbols.
- Produces the 31-symbol codewords that the RS decoder's receive FIFO and syndrome path consume, in the same symbol order: 27 message symbols, highest-degree first, then 4 parity symbols.
- Single clock, valid/ready handshakes on both sides, one registered output stage.

Parameters:
- SYM_W, 5, symbol width in bits.
- N, 31, codeword length in symbols.
- K, 27, message length in symbols. Only the defaults are supported; any other value is an elaboration-time error.

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, asynchronous, active-high.
- in_valid, in, 1, datain holds a message symbol.
- in_ready, out, 1, encoder accepts the symbol this cycle.
- datain, in, 5, message symbol.
- out_valid, out, 1, dataout holds a codeword symbol.
- out_ready, in, 1, downstream consumes dataout this cycle.
- dataout, out, 5, codeword symbol.
- out_first, out, 1, dataout is codeword symbol 0.
- out_last, out, 1, dataout is codeword symbol 30, the last parity symbol.

Behaviour:
- Generator polynomial g(x) = x^4 + a^24·x^3 + a^19·x^2 + a^29·x + a^10. Coefficients in decimal: G3=30, G2=6, G1=9, G0=17.
- State: LFSR registers r0..r3 (5 bits each), FSM {MSG, PAR}, counter cnt (5 bits).
- Reset (async, takes effect immediately, including mid-codeword):
  - r0..r3 = 0, state = MSG, cnt = 0.
  - dataout = 0, out_valid = 0, out_first = 0, out_last = 0.
  - in_ready = 0 while reset is asserted.
  - Any partial codeword is discarded.
- Output register free condition: free = !out_valid || out_ready.
- in_ready = (state == MSG) && free. This is combinational; it is 0 throughout PAR.
- MSG state, on each accept (in_valid && in_ready):
  - fb = datain ^ r3.
  - r3 <= r2 ^ fb·G3; r2 <= r1 ^ fb·G2; r1 <= r0 ^ fb·G1; r0 <= fb·G0 (GF multiply).
  - dataout <= datain, out_valid <= 1.
  - out_first <= (cnt == 0), out_last <= 0, cnt++.
  - On the accept with cnt == 26: state <= PAR, cnt <= 0.
- PAR state, on each cycle where free:
  - dataout <= r3, out_valid <= 1, out_first <= 0.
  - Shift r3 <= r2, r2 <= r1, r1 <= r0, r0 <= 0; cnt++.
  - On cnt == 3: out_last <= 1, state <= MSG, cnt <= 0, r0..r3 end at 0.
- If free && no load this cycle: out_valid <= 0, out_first <= 0, out_last <= 0.
- If out_valid && !out_ready: dataout and the flags hold stable; the LFSR and cnt do not advance.
- Latency and throughput:
  - One cycle from a message-symbol accept to its appearance on dataout.
  - Full throughput of 1 symbol per cycle when out_ready is held high.
  - Back-to-back codewords: the first symbol of the next message is accepted in the cycle its predecessor, the last parity symbol, is consumed.
- in_valid with no accept has no effect. datain is ignored when in_ready = 0.

Optional Feature:
- Macro RS_ENC_ERR_INJ_EN adds inputs err_en (1), err_pos (5), err_val (5).
- These inputs are sampled on the accept of codeword symbol 0 and held for that codeword.
- When the sampled err_en = 1, the symbol with index err_pos (0..30) is emitted as its true value XOR err_val. The LFSR always uses the clean datain.
- err_pos > 30 means no injection.
- Without the macro, the ports do not exist and the output is always clean.

Decomposition:
- Shared package rs_pkg holds:
  - SYM_W, N, K, NPAR=4;
  - PRIM_POLY = 5'b00101;
  - G0..G3 constants;
  - the encoder state enum {MSG, PAR}.
- Sub-module gf_mult5: combinational GF(2^5) multiplier using PRIM_POLY. It is instantiated four times for fb·Gi, and the decoder's syndrome cells reuse it.

Test Plan:
- All-zero message, out_ready = 1 → 31 zero symbols; out_first on symbol 0, out_last on symbol 30; next codeword's first symbol is accepted the cycle after.
- Message of 26 zeros then 1 → parity symbols 30, 6, 9, 17 in that order.
- 200 random messages with random in_valid/out_ready gaps → output matches the reference model, and all syndromes S1..S4 at alpha^1..alpha^4 are 0.
- out_ready low for 5 cycles while parity symbol 1 is presented → dataout holds 6, in_ready stays 0, and no symbol is lost or duplicated.
- Reset asserted after message symbol 10 → all outputs are 0 immediately; the following 26-zeros-then-1 codeword again yields parity 30, 6, 9, 17.
- With RS_ENC_ERR_INJ_EN: zero message, err_en = 1, err_pos = 30, err_val = 1 → symbols 0..29 are 0 and symbol 30 is 1.
